// File: rtl/t_4_join.sv
// t_4_join: pairs words from two independently buffered input streams in
// arrival order and emits their 32-bit wrap-around sum as one AXI-stream.
// An ap_start/ap_done controller bounds each run to FRAME_LEN output words.
module t_4_join #(
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 16
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [31:0] Input_1_V_TDATA,
    input  logic        Input_1_V_TVALID,
    output logic        Input_1_V_TREADY,
    input  logic [31:0] Input_2_V_TDATA,
    input  logic        Input_2_V_TVALID,
    output logic        Input_2_V_TREADY,
    output logic [31:0] Output_1_V_TDATA,
    output logic        Output_1_V_TVALID,
    input  logic        Output_1_V_TREADY
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [16:0]   FRAME_C = 17'(FRAME_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [31:0]   a_mem [DEPTH];
    logic [AW-1:0] a_wr, a_rd;
    logic [CW-1:0] a_cnt;
    logic [31:0]   b_mem [DEPTH];
    logic [AW-1:0] b_wr, b_rd;
    logic [CW-1:0] b_cnt;

    logic [16:0] issued, sent;
    logic        a_push, b_push, a_nempty, b_nempty;
    logic        load, out_hs;

    // FIFOs accept whenever they have room, regardless of run state
    assign Input_1_V_TREADY = (a_cnt < DEPTH_C);
    assign Input_2_V_TREADY = (b_cnt < DEPTH_C);
    assign a_push   = Input_1_V_TVALID && Input_1_V_TREADY;
    assign b_push   = Input_2_V_TVALID && Input_2_V_TREADY;
    assign a_nempty = (a_cnt != '0);
    assign b_nempty = (b_cnt != '0);

    assign out_hs = Output_1_V_TVALID && Output_1_V_TREADY;
    assign load   = (state == S_RUN) && a_nempty && b_nempty &&
                    (issued < FRAME_C) &&
                    (!Output_1_V_TVALID || Output_1_V_TREADY);

    // Operand A storage (contents need no reset; pointers define validity)
    always_ff @(posedge ap_clk) begin
        if (a_push) a_mem[a_wr] <= Input_1_V_TDATA;
    end

    // Operand A pointers and occupancy
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            a_wr  <= '0;
            a_rd  <= '0;
            a_cnt <= '0;
        end else begin
            if (a_push) a_wr <= a_wr + AW'(1);
            if (load)   a_rd <= a_rd + AW'(1);
            case ({a_push, load})
                2'b10:   a_cnt <= a_cnt + CW'(1);
                2'b01:   a_cnt <= a_cnt - CW'(1);
                default: a_cnt <= a_cnt;
            endcase
        end
    end

    // Operand B storage
    always_ff @(posedge ap_clk) begin
        if (b_push) b_mem[b_wr] <= Input_2_V_TDATA;
    end

    // Operand B pointers and occupancy
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            b_wr  <= '0;
            b_rd  <= '0;
            b_cnt <= '0;
        end else begin
            if (b_push) b_wr <= b_wr + AW'(1);
            if (load)   b_rd <= b_rd + AW'(1);
            case ({b_push, load})
                2'b10:   b_cnt <= b_cnt + CW'(1);
                2'b01:   b_cnt <= b_cnt - CW'(1);
                default: b_cnt <= b_cnt;
            endcase
        end
    end

    // Output register: load the head sum, or drain on handshake
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            Output_1_V_TDATA  <= '0;
            Output_1_V_TVALID <= 1'b0;
        end else if (load) begin
            Output_1_V_TDATA  <= a_mem[a_rd] + b_mem[b_rd];
            Output_1_V_TVALID <= 1'b1;
        end else if (out_hs) begin
            Output_1_V_TVALID <= 1'b0;
        end
    end

    // Frame counters: cleared on run start, stepped by loads and handshakes
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            issued <= '0;
            sent   <= '0;
        end else if (state == S_IDLE && ap_start) begin
            issued <= '0;
            sent   <= '0;
        end else begin
            if (load)   issued <= issued + 17'd1;
            if (out_hs) sent   <= sent + 17'd1;
        end
    end

    // Control state register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_n  = state;
        ap_idle  = 1'b0;
        ap_done  = 1'b0;
        ap_ready = 1'b0;
        case (state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) state_n = S_RUN;
            end
            S_RUN: begin
                if (out_hs && (sent + 17'd1 == FRAME_C)) state_n = S_DONE;
            end
            S_DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_t_4_join.sv
// tb_t_4_join: directed scoreboard bench for t_4_join (DEPTH=4, FRAME_LEN=4).
module tb_t_4_join;

    localparam int DEPTH = 4;
    localparam int FRAME = 4;

    logic        clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_idle, ap_ready;
    logic [31:0] in1_data = '0;
    logic        in1_valid = 1'b0;
    logic        in1_ready;
    logic [31:0] in2_data = '0;
    logic        in2_valid = 1'b0;
    logic        in2_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int errors = 0;
    int checks = 0;
    int hs_total = 0;
    int done_total = 0;

    logic [31:0] aq[$];
    logic [31:0] bq[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    t_4_join #(.DEPTH(DEPTH), .FRAME_LEN(FRAME)) dut (
        .ap_clk            (clk),
        .ap_rst            (ap_rst),
        .ap_start          (ap_start),
        .ap_done           (ap_done),
        .ap_idle           (ap_idle),
        .ap_ready          (ap_ready),
        .Input_1_V_TDATA   (in1_data),
        .Input_1_V_TVALID  (in1_valid),
        .Input_1_V_TREADY  (in1_ready),
        .Input_2_V_TDATA   (in2_data),
        .Input_2_V_TVALID  (in2_valid),
        .Input_2_V_TREADY  (in2_ready),
        .Output_1_V_TDATA  (out_data),
        .Output_1_V_TVALID (out_valid),
        .Output_1_V_TREADY (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Stream drivers: change inputs on the falling edge; a word is consumed
    // when it was valid and TREADY was high across the following rising edge.
    logic a_r = 1'b0;
    logic b_r = 1'b0;
    always @(negedge clk) begin
        if (in1_valid && a_r && aq.size() > 0) void'(aq.pop_front());
        if (in2_valid && b_r && bq.size() > 0) void'(bq.pop_front());
        in1_valid = (aq.size() > 0);
        in1_data  = (aq.size() > 0) ? aq[0] : '0;
        in2_valid = (bq.size() > 0);
        in2_data  = (bq.size() > 0) ? bq[0] : '0;
        a_r = in1_ready;
        b_r = in2_ready;
    end

    // Output monitor: scoreboard compare, hold-under-stall, done timing
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = '0;
    logic        exp_done = 1'b0;
    int          hs_frame = 0;
    always @(negedge clk) begin
        if (ap_rst) begin
            hs_frame   = 0;
            exp_done   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("done_timing", 32'(ap_done), 32'(exp_done));
            check("ready_eq_done", 32'(ap_ready), 32'(ap_done));
            exp_done = 1'b0;
            if (ap_done) done_total++;
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, stall_data);
            end
            if (out_valid && out_ready) begin
                hs_total++;
                if (exp_q.size() == 0) check("spurious_output", 32'(exp_q.size()), 32'd1);
                else check("out_data", out_data, exp_q.pop_front());
                hs_frame++;
                if (hs_frame == FRAME) begin
                    hs_frame = 0;
                    exp_done = 1'b1;
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        aq.push_back(a);
        bq.push_back(b);
        exp_q.push_back(a + b);
    endtask

    task automatic start_run();
        check("idle_before_start", 32'(ap_idle), 32'd1);
        ap_start = 1'b1;
        tick(1);
        ap_start = 1'b0;
        check("idle_low_after_start", 32'(ap_idle), 32'd0);
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_total < target && n < 200) begin
            tick(1);
            n++;
        end
        check("hs_count", 32'(hs_total), 32'(target));
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_total < target && n < 50) begin
            tick(1);
            n++;
        end
        check("done_count", 32'(done_total), 32'(target));
        check("idle_after_done", 32'(ap_idle), 32'd1);
    endtask

    // Counts falling edges from the first drive of new words until TVALID
    task automatic check_latency(input string tag, input int expv);
        int lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check(tag, 32'(lat), 32'(expv));
    endtask

    initial begin
        // Reset state
        tick(2);
        ap_rst = 1'b0;
        check("rst_idle", 32'(ap_idle), 32'd1);
        check("rst_done", 32'(ap_done), 32'd0);
        check("rst_ready", 32'(ap_ready), 32'd0);
        check("rst_tvalid", 32'(out_valid), 32'd0);
        check("rst_tdata", out_data, 32'd0);
        check("rst_in1_ready", 32'(in1_ready), 32'd1);
        check("rst_in2_ready", 32'(in2_ready), 32'd1);

        // Basic run: 11,22,33,44 with two-cycle latency
        start_run();
        push_pair(32'd1, 32'd10);
        push_pair(32'd2, 32'd20);
        push_pair(32'd3, 32'd30);
        push_pair(32'd4, 32'd40);
        check_latency("basic_latency", 2);
        tick(1);
        wait_hs(4);
        wait_done(1);

        // Wrap-around arithmetic
        start_run();
        push_pair(32'hFFFF_FFFF, 32'h0000_0002);
        push_pair(32'h8000_0000, 32'h8000_0000);
        push_pair(32'h0000_0001, 32'hFFFF_FFFE);
        push_pair(32'h1234_5678, 32'h0000_0000);
        wait_hs(8);
        wait_done(2);

        // Skew: A arrives alone and fills its FIFO, B follows later
        start_run();
        for (int unsigned i = 0; i < 4; i++) begin
            aq.push_back(32'(i + 5));
            exp_q.push_back(32'(i + 5) + 32'(100 * (i + 1)));
        end
        tick(10);
        check("skew_in1_full", 32'(in1_ready), 32'd0);
        check("skew_in2_ready", 32'(in2_ready), 32'd1);
        check("skew_no_output", 32'(out_valid), 32'd0);
        for (int unsigned i = 0; i < 4; i++) bq.push_back(32'(100 * (i + 1)));
        check_latency("skew_latency", 2);
        tick(1);
        wait_hs(12);
        wait_done(3);

        // Backpressure with 6 pairs; frame of 4 leaves 2 pairs buffered
        out_ready = 1'b0;
        start_run();
        push_pair(32'd1, 32'd10);
        push_pair(32'd2, 32'd20);
        push_pair(32'd3, 32'd30);
        push_pair(32'd4, 32'd40);
        push_pair(32'd5, 32'd50);
        push_pair(32'd6, 32'd60);
        tick(10);
        check("bp_in1_full", 32'(in1_ready), 32'd0);
        check("bp_in2_full", 32'(in2_ready), 32'd0);
        check("bp_tvalid", 32'(out_valid), 32'd1);
        check("bp_tdata", out_data, 32'd11);
        out_ready = 1'b1;
        wait_hs(16);
        wait_done(4);
        tick(6);
        check("boundary_no_extra", 32'(hs_total), 32'd16);
        check("boundary_tvalid", 32'(out_valid), 32'd0);
        check("boundary_leftover", 32'(in1_ready), 32'd1);

        // Second run drains the leftovers first
        start_run();
        push_pair(32'd7, 32'd70);
        push_pair(32'd8, 32'd80);
        wait_hs(20);
        wait_done(5);

        // Reset mid-run after two outputs with A holding two words
        start_run();
        push_pair(32'd3, 32'd30);
        push_pair(32'd4, 32'd40);
        wait_hs(22);
        out_ready = 1'b0;
        aq.push_back(32'd9);
        aq.push_back(32'd9);
        tick(5);
        check("pre_rst_aq_empty", 32'(aq.size()), 32'd0);
        ap_rst = 1'b1;
        tick(1);
        ap_rst = 1'b0;
        check("midrst_tvalid", 32'(out_valid), 32'd0);
        check("midrst_idle", 32'(ap_idle), 32'd1);
        check("midrst_in1_ready", 32'(in1_ready), 32'd1);
        check("midrst_in2_ready", 32'(in2_ready), 32'd1);
        out_ready = 1'b1;
        tick(1);
        start_run();
        push_pair(32'd100, 32'd1000);
        push_pair(32'd200, 32'd2000);
        push_pair(32'd300, 32'd3000);
        push_pair(32'd400, 32'd4000);
        wait_hs(26);
        wait_done(6);

        tick(3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
